mux_scan_ctrl: RTL and testbench

//  Sequencer that sits directly upstream of the 4:1 bit multiplexer. Drives its
//  SEL lines through channels 0..3 and samples the mux DOUT back. Packs the four

---
 rtl/mux_scan_pkg.sv | 11 +
 rtl/mux_scan_settle_cnt.sv | 36 +++
 rtl/mux_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants for the mux scan sequencer: channel geometry and FSM encoding.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/mux_scan_settle_cnt.sv
// Loadable down-counter used to hold each mux channel for its settle time.
module mux_scan_settle_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux through its channels, samples DOUT after a settle time and
// hands the packed 4-bit word downstream over valid/ready.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_W = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                CONT,
    input  logic [SETTLE_W-1:0] SETTLE,
    output logic [SEL_W-1:0]    SEL,
    input  logic                MUX_OUT,
    output logic [NUM_CH-1:0]   SCAN_DATA,
    output logic                SCAN_VALID,
    input  logic                SCAN_READY,
    output logic                BUSY,
    output logic                START_ERR
);

    logic [1:0]          state_q,  state_d;
    logic [SEL_W-1:0]    sel_q,    sel_d;
    logic [NUM_CH-2:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0]   data_q,   data_d;
    logic                valid_q,  valid_d;
    logic                err_q,    err_d;
    logic                cont_q,   cont_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    logic                shadow_we;
    logic                cnt_load;
    logic                cnt_en;
    logic                cnt_zero;
    logic [SETTLE_W-1:0] cnt_value;

    mux_scan_settle_cnt #(
        .W (SETTLE_W)
    ) u_settle_cnt (
        .clk   (CLK),
        .srst  (RST),
        .load  (cnt_load),
        .value (cnt_value),
        .en    (cnt_en),
        .zero  (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        data_d    = data_q;
        valid_d   = valid_q;
        err_d     = err_q;
        cont_d    = cont_q;
        settle_d  = settle_q;
        shadow_we = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        cnt_value = settle_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    sel_d     = '0;
                    cnt_load  = 1'b1;
                    cnt_value = SETTLE;
                    settle_d  = SETTLE;
                    cont_d    = CONT;
                    err_d     = 1'b0;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (START) begin
                    err_d = 1'b1;
                end
                if (!cnt_zero) begin
                    cnt_en = 1'b1;
                end else if (sel_q != SEL_W'(NUM_CH - 1)) begin
                    shadow_we = 1'b1;
                    sel_d     = sel_q + SEL_W'(1);
                    cnt_load  = 1'b1;
                end else begin
                    // Last channel goes straight into the output word, not the shadow.
                    data_d  = {MUX_OUT, shadow_q};
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (START) begin
                    err_d = 1'b1;
                end
                if (SCAN_READY) begin
                    valid_d = 1'b0;
                    sel_d   = '0;
                    if (cont_q) begin
                        cnt_load  = 1'b1;
                        cnt_value = SETTLE;
                        settle_d  = SETTLE;
                        cont_d    = CONT;
                        state_d   = ST_SCAN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_CH - 1; gi++) begin : g_shadow
        assign shadow_d[gi] = (shadow_we && (sel_q == SEL_W'(gi))) ? MUX_OUT : shadow_q[gi];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            cont_q   <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            cont_q   <= cont_d;
            settle_q <= settle_d;
        end
    end

    assign SEL        = sel_q;
    assign SCAN_DATA  = data_q;
    assign SCAN_VALID = valid_q;
    assign START_ERR  = err_q;
    assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl paired with a behavioural 4:1 mux whose DIN is driven here.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cont;
    logic [3:0] settle;
    logic [3:0] din;
    logic       ready;
    logic [1:0] sel;
    logic       mux_out;
    logic [3:0] scan_data;
    logic       scan_valid;
    logic       busy;
    logic       start_err;

    always #5 clk = ~clk;

    assign mux_out = din[sel];

    mux_scan_ctrl #(.SETTLE_W(4)) dut (
        .CLK        (clk),
        .RST        (rst),
        .START      (start),
        .CONT       (cont),
        .SETTLE     (settle),
        .SEL        (sel),
        .MUX_OUT    (mux_out),
        .SCAN_DATA  (scan_data),
        .SCAN_VALID (scan_valid),
        .SCAN_READY (ready),
        .BUSY       (busy),
        .START_ERR  (start_err)
    );

    int         n_cmp  = 0;
    int         n_err  = 0;
    int         n_xfer = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [3:0] settle;
        logic [3:0] din;
        int         ready_wait;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    // Counts every valid/ready transfer the DUT performs.
    always @(negedge clk) begin
        if (!rst && scan_valid && ready) n_xfer <= n_xfer + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int lat);
        lat = 0;
        while (!scan_valid && lat < max) begin
            tick();
            lat++;
        end
        check("valid_within_budget", scan_valid, 1);
    endtask

    task automatic handshake(input string name);
        logic [3:0] req;
        check("hs_valid", scan_valid, 1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: word 0x%0h with no expected entry", name, scan_data);
        end else begin
            req = exp_q.pop_front();
            check(name, scan_data, req);
            $display("xfer %s: data=0x%0h expected=0x%0h", name, scan_data, req);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("hs_valid_drop", scan_valid, 0);
    endtask

    task automatic sel_seq(input logic [3:0] s, input logic [3:0] d);
        int per;
        per    = int'(s) + 1;
        settle = s;
        din    = d;
        pulse_start();
        exp_q.push_back(d);
        for (int c = 0; c < 4 * per; c++) begin
            check("sel_step", sel, c / per);
            check("sel_no_valid", scan_valid, 0);
            tick();
        end
        check("sel_valid_on_time", scan_valid, 1);
        check("sel_hold_3", sel, 3);
        handshake("sel_seq_data");
        check("sel_busy_after", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int x0;
        int vcount;
        int k;

        vecs[0] = '{4'd0,  4'b1010, 0, 4};
        vecs[1] = '{4'd3,  4'b0110, 2, 16};
        vecs[2] = '{4'd1,  4'b1111, 5, 8};
        vecs[3] = '{4'd2,  4'b0001, 0, 12};
        vecs[4] = '{4'd15, 4'b1000, 1, 64};
        vecs[5] = '{4'd7,  4'b0000, 3, 32};

        rst = 1'b1; start = 1'b0; cont = 1'b0; ready = 1'b0; settle = '0; din = '0;
        repeat (3) tick();
        check("rst_sel", sel, 0);
        check("rst_valid", scan_valid, 0);
        check("rst_data", scan_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", start_err, 0);
        rst = 1'b0;
        tick();

        // Table-driven single scans; SETTLE is disturbed after accept and must not matter.
        for (int i = 0; i < 6; i++) begin
            settle = vecs[i].settle;
            din    = vecs[i].din;
            cont   = 1'b0;
            pulse_start();
            exp_q.push_back(vecs[i].din);
            settle = ~vecs[i].settle;
            check("vec_busy", busy, 1);
            wait_valid(100, lat);
            check("vec_latency", lat, vecs[i].exp_lat);
            repeat (vecs[i].ready_wait) tick();
            handshake("vec_data");
            check("vec_busy_after", busy, 0);
            check("vec_sel_after", sel, 0);
        end

        // SEL stepping for SETTLE=0 and SETTLE=3.
        sel_seq(4'd0, 4'b1010);
        sel_seq(4'd3, 4'b0110);

        // READY withheld while DIN changes: word must stay captured.
        settle = 4'd0; din = 4'b0110; cont = 1'b0;
        pulse_start();
        exp_q.push_back(4'b0110);
        wait_valid(100, lat);
        din = 4'hF;
        x0  = n_xfer;
        for (int c = 0; c < 10; c++) begin
            check("hold_valid", scan_valid, 1);
            check("hold_data", scan_data, 4'b0110);
            tick();
        end
        handshake("hold_xfer");
        ready = 1'b1;
        repeat (3) tick();
        ready = 1'b0;
        check("hold_one_xfer", n_xfer - x0, 1);
        check("hold_busy_after", busy, 0);

        // Continuous mode: new scan starts on handshake edge; CONT dropped mid-scan.
        settle = 4'd0; din = 4'h5; cont = 1'b1;
        pulse_start();
        exp_q.push_back(4'h5);
        wait_valid(100, lat);
        check("cont_lat1", lat, 4);
        din = 4'hC;
        exp_q.push_back(4'hC);
        handshake("cont_word1");
        check("cont_busy1", busy, 1);
        check("cont_sel_restart", sel, 0);
        tick();
        cont = 1'b0;
        wait_valid(100, lat);
        check("cont_lat2", lat, 3);
        din = 4'h3;
        exp_q.push_back(4'h3);
        handshake("cont_word2");
        check("cont_busy2", busy, 1);
        wait_valid(100, lat);
        check("cont_lat3", lat, 4);
        handshake("cont_word3");
        check("cont_idle", busy, 0);

        // START while busy: ignored, sticky error, cleared by next accept.
        settle = 4'd2; din = 4'b1001; cont = 1'b0;
        pulse_start();
        exp_q.push_back(4'b1001);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("err_set", start_err, 1);
        check("err_busy", busy, 1);
        wait_valid(100, lat);
        check("err_scan_latency", lat + 4, 12);
        handshake("err_scan_data");
        check("err_sticky_idle", start_err, 1);
        settle = 4'd0; din = 4'b0011;
        pulse_start();
        exp_q.push_back(4'b0011);
        check("err_cleared", start_err, 0);
        wait_valid(100, lat);
        handshake("err_next_data");

        // Reset in the middle of a scan at SEL=2.
        settle = 4'd1; din = 4'b1111;
        pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (sel != 2'd2 && k < 50) begin
            tick();
            k++;
        end
        check("rst_mid_sel2", sel, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_sel", sel, 0);
        check("rst_mid_valid", scan_valid, 0);
        check("rst_mid_data", scan_data, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_err", start_err, 0);
        ready  = 1'b1;
        vcount = 0;
        repeat (20) begin
            tick();
            if (scan_valid) vcount++;
        end
        ready = 1'b0;
        check("rst_mid_no_valid", vcount, 0);

        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
